// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_port_arbiter
// Purpose  : Round-robin arbiter sharing one 128-bit data-memory port between
//            N_CORES cores. Optional watchdog enabled by ARB_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module memory_port_arbiter #(
    parameter int N_CORES        = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ID_W           = $clog2(N_CORES)
) (
    input  logic                   clock,
    input  logic                   async_reset,
    input  logic [N_CORES-1:0]     core_transaction,
    input  logic [N_CORES-1:0]     core_write,
    input  logic [N_CORES*32-1:0]  core_address,
    input  logic [N_CORES*128-1:0] core_write_data,
    input  logic [N_CORES*16-1:0]  core_byte_enablers,
    output logic [N_CORES-1:0]     core_data_ready,
    output logic [127:0]           core_read_data,
    output logic                   mem_valid,
    output logic                   mem_write,
    output logic [31:0]            mem_address,
    output logic [127:0]           mem_write_data,
    output logic [15:0]            mem_byte_enablers,
    input  logic                   mem_done,
    input  logic [127:0]           mem_read_data,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
`ifdef ARB_WATCHDOG_EN
    ,
    output logic                   timeout_error
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    if (N_CORES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("memory_port_arbiter: N_CORES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_pointer_q, rr_pointer_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               mem_valid_q, mem_valid_d;
    logic               mem_write_q, mem_write_d;
    logic [31:0]        mem_address_q, mem_address_d;
    logic [127:0]       mem_write_data_q, mem_write_data_d;
    logic [15:0]        mem_byte_enablers_q, mem_byte_enablers_d;
    logic [N_CORES-1:0] core_data_ready_q, core_data_ready_d;
    logic [127:0]       core_read_data_q, core_read_data_d;
    logic               busy_q, busy_d;

`ifdef ARB_WATCHDOG_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               timeout_error_q, timeout_error_d;
`endif

    logic               winner_found;
    logic [ID_W-1:0]    winner;
    int                 search_idx;

    // First requester at or after rr_pointer, wrapping around the core list.
    always_comb begin
        winner_found = 1'b0;
        winner       = '0;
        search_idx   = 0;
        for (int i = 0; i < N_CORES; i++) begin
            search_idx = int'(rr_pointer_q) + i;
            if (search_idx >= N_CORES) begin
                search_idx = search_idx - N_CORES;
            end
            if (!winner_found && core_transaction[search_idx]) begin
                winner_found = 1'b1;
                winner       = ID_W'(search_idx);
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        rr_pointer_d        = rr_pointer_q;
        grant_id_d          = grant_id_q;
        mem_write_d         = mem_write_q;
        mem_address_d       = mem_address_q;
        mem_write_data_d    = mem_write_data_q;
        mem_byte_enablers_d = mem_byte_enablers_q;
        core_data_ready_d   = '0;
        core_read_data_d    = core_read_data_q;
`ifdef ARB_WATCHDOG_EN
        count_d             = count_q;
        timeout_error_d     = timeout_error_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (winner_found) begin
                    grant_id_d          = winner;
                    mem_write_d         = core_write[winner];
                    mem_address_d       = core_address[32*int'(winner) +: 32];
                    mem_write_data_d    = core_write_data[128*int'(winner) +: 128];
                    mem_byte_enablers_d = core_byte_enablers[16*int'(winner) +: 16];
                    state_d             = ST_BUSY;
`ifdef ARB_WATCHDOG_EN
                    count_d             = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (mem_done) begin
                    core_read_data_d              = mem_write_q ? 128'b0 : mem_read_data;
                    core_data_ready_d[grant_id_q] = 1'b1;
                    state_d                       = ST_RESPOND;
                end
`ifdef ARB_WATCHDOG_EN
                else if (count_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES)) begin
                    // Memory never answered: release the core with zero data.
                    core_read_data_d              = 128'b0;
                    core_data_ready_d[grant_id_q] = 1'b1;
                    timeout_error_d               = 1'b1;
                    state_d                       = ST_RESPOND;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
`endif
            end
            ST_RESPOND: begin
                if (grant_id_q == ID_W'(N_CORES - 1)) begin
                    rr_pointer_d = '0;
                end else begin
                    rr_pointer_d = grant_id_q + ID_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        mem_valid_d = (state_d == ST_BUSY);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state_q             <= ST_IDLE;
            rr_pointer_q        <= '0;
            grant_id_q          <= '0;
            mem_valid_q         <= 1'b0;
            mem_write_q         <= 1'b0;
            mem_address_q       <= '0;
            mem_write_data_q    <= '0;
            mem_byte_enablers_q <= '0;
            core_data_ready_q   <= '0;
            core_read_data_q    <= '0;
            busy_q              <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            count_q             <= '0;
            timeout_error_q     <= 1'b0;
`endif
        end else begin
            state_q             <= state_d;
            rr_pointer_q        <= rr_pointer_d;
            grant_id_q          <= grant_id_d;
            mem_valid_q         <= mem_valid_d;
            mem_write_q         <= mem_write_d;
            mem_address_q       <= mem_address_d;
            mem_write_data_q    <= mem_write_data_d;
            mem_byte_enablers_q <= mem_byte_enablers_d;
            core_data_ready_q   <= core_data_ready_d;
            core_read_data_q    <= core_read_data_d;
            busy_q              <= busy_d;
`ifdef ARB_WATCHDOG_EN
            count_q             <= count_d;
            timeout_error_q     <= timeout_error_d;
`endif
        end
    end

    assign core_data_ready   = core_data_ready_q;
    assign core_read_data    = core_read_data_q;
    assign mem_valid         = mem_valid_q;
    assign mem_write         = mem_write_q;
    assign mem_address       = mem_address_q;
    assign mem_write_data    = mem_write_data_q;
    assign mem_byte_enablers = mem_byte_enablers_q;
    assign grant_id          = grant_id_q;
    assign busy              = busy_q;
`ifdef ARB_WATCHDOG_EN
    assign timeout_error     = timeout_error_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_port_arbiter
// Purpose  : Scoreboard bench for memory_port_arbiter (watchdog section runs
//            when ARB_WATCHDOG_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_port_arbiter;

    localparam int N = 4;
`ifdef ARB_WATCHDOG_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic           clock = 1'b0;
    logic           async_reset = 1'b1;
    logic [N-1:0]   core_transaction = '0;
    logic [N-1:0]   core_write = '0;
    logic [N*32-1:0]  core_address = '0;
    logic [N*128-1:0] core_write_data = '0;
    logic [N*16-1:0]  core_byte_enablers = '0;
    logic [N-1:0]   core_data_ready;
    logic [127:0]   core_read_data;
    logic           mem_valid, mem_write, mem_done, busy;
    logic [31:0]    mem_address;
    logic [127:0]   mem_write_data, mem_read_data;
    logic [15:0]    mem_byte_enablers;
    logic [1:0]     grant_id;
`ifdef ARB_WATCHDOG_EN
    logic           timeout_error;
`endif

    always #5 clock = ~clock;

    memory_port_arbiter #(.N_CORES(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .async_reset(async_reset),
        .core_transaction(core_transaction), .core_write(core_write),
        .core_address(core_address), .core_write_data(core_write_data),
        .core_byte_enablers(core_byte_enablers),
        .core_data_ready(core_data_ready), .core_read_data(core_read_data),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_byte_enablers(mem_byte_enablers),
        .mem_done(mem_done), .mem_read_data(mem_read_data),
        .grant_id(grant_id), .busy(busy)
`ifdef ARB_WATCHDOG_EN
        , .timeout_error(timeout_error)
`endif
    );

    function automatic logic [127:0] mem_model(input logic [31:0] a);
        return {32'hDEAD0000, a, ~a, 32'h0000BEEF};
    endfunction

    // Memory model: answers mem_wait cycles after the first BUSY cycle.
    int   bw = 0;
    int   mem_wait = 0;
    logic force_done = 1'b0;
    always @(posedge clock or posedge async_reset) begin
        if (async_reset)              bw <= 0;
        else if (!mem_valid || mem_done) bw <= 0;
        else                          bw <= bw + 1;
    end
    assign mem_done      = (mem_valid && bw == mem_wait) || force_done;
    assign mem_read_data = mem_model(mem_address);

    typedef struct { int id; logic [127:0] data; } exp_t;
    exp_t sb[$];
    int   rem[N];
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0, last_rise = -1;
    logic mv_prev = 1'b0, rr_chk = 1'b0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [127:0] d);
        exp_t e;
        e.id = id; e.data = d;
        sb.push_back(e);
    endtask

    task automatic req(input int id, input logic wr, input logic [31:0] a,
                       input logic [127:0] d, input logic [15:0] be, input int n);
        core_write[id]                    = wr;
        core_address[32*id +: 32]         = a;
        core_write_data[128*id +: 128]    = d;
        core_byte_enablers[16*id +: 16]   = be;
        core_transaction[id]              = 1'b1;
        rem[id]                           = n;
    endtask

    // One clock: sample #1 after the edge, score responses, retire requests.
    task automatic step();
        exp_t e;
        logic [N-1:0] oh;
        @(posedge clock);
        #1;
        cyc++;
        if (mem_valid && !mv_prev) begin
            if (rr_chk && last_rise >= 0) check("rr_spacing", 128'(cyc - last_rise), 128'd3);
            last_rise = cyc;
        end
        mv_prev = mem_valid;
        if (core_data_ready != '0) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {124'b0, core_data_ready}, 128'b0);
            end else begin
                e  = sb.pop_front();
                oh = '0;
                oh[e.id] = 1'b1;
                check("sb_ready", {124'b0, core_data_ready}, {124'b0, oh});
                check("sb_data", core_read_data, e.data);
            end
            for (int i = 0; i < N; i++) begin
                if (core_data_ready[i] && rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) core_transaction[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < max) begin
            step();
            n++;
        end
        check(tag, {126'b0, sb.size() != 0, busy}, 128'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [127:0] wdata;
        int n;
        for (int i = 0; i < N; i++) rem[i] = 0;

        // Reset values
        step();
        check("rst_mem_valid", {127'b0, mem_valid}, 128'b0);
        check("rst_busy", {127'b0, busy}, 128'b0);
        check("rst_ready", {124'b0, core_data_ready}, 128'b0);
        check("rst_rdata", core_read_data, 128'b0);
        check("rst_fields", {mem_write, mem_address, mem_byte_enablers, grant_id}, 128'b0);
        check("rst_wdata", mem_write_data, 128'b0);
        async_reset = 1'b0;
        step();

        // Single read, zero-wait memory
        mem_wait = 0;
        req(1, 1'b0, 32'h0000_0040, 128'b0, 16'hFFFF, 1);
        push(1, mem_model(32'h0000_0040));
        step();
        check("rd_mem_valid", {127'b0, mem_valid}, 128'd1);
        check("rd_grant", {126'b0, grant_id}, 128'd1);
        check("rd_addr", {96'b0, mem_address}, 128'h40);
        step();
        check("rd_ready", {124'b0, core_data_ready}, 128'b0010);
        check("rd_respond_valid", {127'b0, mem_valid}, 128'b0);
        step();
        check("rd_idle_busy", {127'b0, busy}, 128'b0);
        check("rd_hold", core_read_data, mem_model(32'h0000_0040));

        // Write with five wait cycles; core inputs change mid-BUSY
        mem_wait = 5;
        wdata = 128'h0123_4567_89AB_CDEF_0011_2233_4455_1234;
        req(2, 1'b1, 32'h0000_0100, wdata, 16'h000F, 1);
        push(2, 128'b0);
        step();
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                core_address[64 +: 32]    = 32'h0000_0200;
                core_write_data[256 +: 128] = ~wdata;
                core_write[2]             = 1'b0;
            end
            check("wr_stable", {mem_valid, mem_write, mem_address, mem_byte_enablers},
                  {78'b0, 1'b1, 1'b1, 32'h0000_0100, 16'h000F});
            check("wr_data", mem_write_data, wdata);
            step();
        end
        check("wr_rdata_zero", core_read_data, 128'b0);
        step();

        // Stray mem_done while idle
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        check("stray_done", {126'b0, busy, mem_valid}, 128'b0);
        step();
        check("stray_ready", {124'b0, core_data_ready}, 128'b0);

        // Core 0 drops its request mid-BUSY
        mem_wait = 3;
        req(0, 1'b0, 32'h0000_0080, 128'b0, 16'hFFFF, 1);
        push(0, mem_model(32'h0000_0080));
        step();
        step();
        core_transaction[0] = 1'b0;
        drain("drop_drain", 20);

        // Reset on the second BUSY cycle
        mem_wait = 10;
        req(3, 1'b0, 32'h0000_0300, 128'b0, 16'hFFFF, 1);
        step();
        check("rb_busy", {127'b0, mem_valid}, 128'd1);
        step();
        async_reset = 1'b1;
        #1;
        check("rb_abort", {125'b0, mem_valid, busy, |core_data_ready}, 128'b0);
        core_transaction = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;

        // Round-robin from reset with all cores requesting
        mem_wait = 0;
        for (int i = 0; i < N; i++) req(i, 1'b0, 32'h1000 + 32'(16 * i), 128'b0, 16'hFFFF, (i == 0) ? 2 : 1);
        for (int i = 0; i < N; i++) push(i, mem_model(32'h1000 + 32'(16 * i)));
        push(0, mem_model(32'h1000));
        step();
        step();
        check("rb_no_ready", {124'b0, core_data_ready}, 128'b0);
        async_reset = 1'b0;
        mv_prev = 1'b0;
        last_rise = -1;
        rr_chk = 1'b1;
        step();
        check("rr_first_grant", {126'b0, grant_id}, 128'd0);
        drain("rr_drain", 60);
        rr_chk = 1'b0;

`ifdef ARB_WATCHDOG_EN
        // Watchdog: memory never answers
        mem_wait = 100000;
        req(1, 1'b0, 32'h0000_0500, 128'b0, 16'hFFFF, 1);
        push(1, 128'b0);
        step();
        n = 0;
        while (mem_valid && n < 40) begin
            n++;
            step();
        end
        check("wd_busy_cycles", 128'(n), 128'd8);
        check("wd_rdata", core_read_data, 128'b0);
        check("wd_flag", {127'b0, timeout_error}, 128'd1);
        step();
        mem_wait = 0;
        req(2, 1'b0, 32'h0000_0600, 128'b0, 16'hFFFF, 1);
        push(2, mem_model(32'h0000_0600));
        drain("wd_drain", 20);
        check("wd_sticky", {127'b0, timeout_error}, 128'd1);
`else
        n = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Round-robin arbiter that shares one 128-bit data-memory port between `N_CORES` RV32I cores. Each core's memory-stage request (`memory_transaction`, `mem_write`, `ALU_result` address, `data_out_bus`, `byte_enablers`) is latched and issued to memory one at a time. The arbiter then returns the read data and a single-cycle `data_ready` pulse to the granted core; the core's hazard unit holds that core's pipeline until the pulse. The block sits between the core array and the shared data memory/cache.

## Interface
Parameters:
- `N_CORES`, default 4: number of requesting cores, ≥2.
- `TIMEOUT_CYCLES`, default 255: watchdog limit, used only with `ARB_WATCHDOG_EN`.
- `ID_W`, default `$clog2(N_CORES)`: grant index width.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  single clock, rising edge.
- `async_reset`  in  1  asynchronous, active-high reset.
- `core_transaction`  in  N_CORES  per-core request, held until that core's `core_data_ready`.
- `core_write`  in  N_CORES  per-core write (1) / read (0).
- `core_address`  in  N_CORES*32  per-core byte address; core i occupies bits [32i+31:32i].
- `core_write_data`  in  N_CORES*128  per-core store data.
- `core_byte_enablers`  in  N_CORES*16  per-core byte enables.
- `core_data_ready`  out  N_CORES  one-hot completion pulse.
- `core_read_data`  out  128  shared read-data bus, valid for the core whose `core_data_ready` bit is high.
- `mem_valid`  out  1  request to memory.
- `mem_write`  out  1  latched write flag.
- `mem_address`  out  32  latched address.
- `mem_write_data`  out  128  latched store data.
- `mem_byte_enablers`  out  16  latched byte enables.
- `mem_done`  in  1  memory completion, sampled only in BUSY.
- `mem_read_data`  in  128  memory read data, valid with `mem_done`.
- `grant_id`  out  ID_W  index of the current or last granted core.
- `busy`  out  1  high in BUSY and RESPOND.
- `timeout_error`  out  1  sticky watchdog flag; present only with `ARB_WATCHDOG_EN`.

## Operation
State machine with three states:

- **IDLE**
  - Search `core_transaction` starting at `rr_pointer`, wrapping modulo `N_CORES`.
  - Choose the first set bit as winner g.
  - Latch g into `grant_id`, and latch core g's write, address, write_data and byte_enablers.
  - Go to BUSY.
  - With no requests, stay in IDLE.
- **BUSY**
  - `mem_valid`=1, driving the latched fields, which stay stable throughout BUSY.
  - On `mem_done`=1: latch `mem_read_data`, or 128'b0 for a write, into `core_read_data`, then go to RESPOND.
  - Input changes from any core are ignored in this state.
- **RESPOND**
  - `core_data_ready[g]`=1 for exactly one cycle.
  - `rr_pointer` ← (g+1) mod `N_CORES`.
  - Go to IDLE.
  - The IDLE cycle that follows lets core g's pipeline advance before its request is sampled again.

Rules:
- Round-robin fairness: a core that keeps requesting waits at most `N_CORES`−1 other transactions.
- A request dropped after grant does not cancel the transaction: it completes and the `data_ready` pulse is still issued.
- `mem_done` in IDLE or RESPOND is ignored.
- `core_read_data` holds its last value until the next RESPOND update.

Reset values (asynchronous, take effect immediately, including mid-transaction):
- State = IDLE, `rr_pointer`=0, `grant_id`=0.
- `mem_valid`=0, `mem_write`=0, `mem_address`=0, `mem_write_data`=0, `mem_byte_enablers`=0.
- `core_data_ready`=0, `core_read_data`=0, `busy`=0, `timeout_error`=0.
- An in-flight memory request is abandoned with no response to the core.

## Timing
- All outputs are registered.
- Request asserted at cycle 0 (arbiter in IDLE) → `mem_valid` high at cycle 1.
- `mem_done` at cycle k≥1 → `core_data_ready` at cycle k+1 → IDLE at cycle k+2.
- Minimum transaction: 3 cycles, for a throughput of one access per 3 cycles with zero-wait memory.
- `mem_done` may arrive combinationally in the first BUSY cycle.

## Configuration
- **`ARB_WATCHDOG_EN` defined**
  - An 8+ bit counter clears on BUSY entry and increments each BUSY cycle without `mem_done`.
  - When the counter reaches `TIMEOUT_CYCLES`, the arbiter drops `mem_valid`, returns 128'b0 on `core_read_data`, and moves to RESPOND (normal pulse to core g).
  - `timeout_error` is set, and stays set until reset.
- **`ARB_WATCHDOG_EN` undefined**
  - No counter and no `timeout_error` port.
  - BUSY waits indefinitely for `mem_done`.

## Test plan
- Single read: core 1 reads 0x0000_0040; memory returns `mem_done` at the first BUSY cycle with data 0xDEAD…BEEF → `mem_valid` at cycle 1, `core_data_ready`=4'b0010 at cycle 2, `core_read_data`=0xDEAD…BEEF.
- Round-robin: all 4 cores request continuously from reset → grant order 0,1,2,3,0; each `core_data_ready` pulse is one cycle wide; consecutive `mem_valid` assertions are 3 cycles apart.
- Write: core 2 writes 128'h…1234 at 0x100 with byte enables 0x000F; `mem_done` after 5 wait cycles → `mem_write`=1, and address, data and enables stay stable across all BUSY cycles; `core_read_data`=0 at RESPOND.
- Stray/late inputs: `mem_done` pulsed in IDLE → no state change. Core 0 deasserts its request mid-BUSY → the transaction still completes and `core_data_ready[0]` pulses.
- Reset mid-BUSY: assert `async_reset` on the 2nd BUSY cycle → `mem_valid`=0 and `busy`=0 immediately, with no `data_ready`. After release, the next grant starts from core 0.
- `ARB_WATCHDOG_EN` with `TIMEOUT_CYCLES`=8 and `mem_done` never asserted → RESPOND after 8 BUSY cycles, `core_read_data`=0, `timeout_error`=1 and still 1 after later successful transactions.
